// File: rtl/stack_pkg.sv
// Op-code constants and sequencer state encoding shared by stack_ctrl and its users.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_PC,
    WR_FL,
    INC,
    RD,
    RD_FL,
    RD_PC
  } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer in front of the data memory: one PUSH/POP/CALL/RET at a time, done after 1/2/2/3 cycles.
// Busy ops deassert op_ready; a failed capacity check still costs one cycle before op_ready returns.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_TOP    = 8'hFF,
  parameter logic [7:0] STACK_BOTTOM = 8'hC0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  output logic       op_ready,
  input  logic [7:0] push_data,
  input  logic [7:0] pc_in,
  input  logic [7:0] flags_in,
  input  logic       err_clr,
  input  logic [7:0] mem_dout,
  output logic [7:0] sp_out,
  output logic       mem_sel_sp,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_din,
  output logic [7:0] pop_data,
  output logic [7:0] pc_out,
  output logic [7:0] flags_out,
  output logic       done,
  output logic       err_ovf,
  output logic       err_unf
);

  state_t     state, state_nxt;
  logic [7:0] sp;
  logic [7:0] occ;
  logic [1:0] op_q;
  logic [7:0] push_q, pc_q, flags_q;
  logic       fail_pend, fail_ovf;
  logic       op_ok, accept;

  assign occ      = STACK_TOP - sp;
  assign sp_out   = sp;
  assign op_ready = (state == IDLE) && !fail_pend;
  assign accept   = op_valid && op_ready;

  // SP points at the next free byte, so free entries = SP - STACK_BOTTOM + 1.
  always_comb begin
    op_ok = 1'b0;
    case (op_code)
      OP_PUSH: op_ok = (sp >= STACK_BOTTOM);
      OP_CALL: op_ok = (sp > STACK_BOTTOM);
      OP_POP:  op_ok = (occ >= 8'd1);
      default: op_ok = (occ >= 8'd2);
    endcase
  end

  always_comb begin
    state_nxt  = state;
    mem_sel_sp = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_din    = 8'h00;
    case (state)
      IDLE: begin
        if (accept && op_ok) begin
          case (op_code)
            OP_PUSH: state_nxt = WR;
            OP_CALL: state_nxt = WR_PC;
            default: state_nxt = INC;
          endcase
        end
      end
      WR: begin
        mem_sel_sp = 1'b1;
        mem_wr     = 1'b1;
        mem_din    = push_q;
        state_nxt  = IDLE;
      end
      WR_PC: begin
        mem_sel_sp = 1'b1;
        mem_wr     = 1'b1;
        mem_din    = pc_q;
        state_nxt  = WR_FL;
      end
      WR_FL: begin
        mem_sel_sp = 1'b1;
        mem_wr     = 1'b1;
        mem_din    = flags_q;
        state_nxt  = IDLE;
      end
      INC:     state_nxt = (op_q == OP_POP) ? RD : RD_FL;
      RD: begin
        mem_sel_sp = 1'b1;
        mem_rd     = 1'b1;
        state_nxt  = IDLE;
      end
      RD_FL: begin
        mem_sel_sp = 1'b1;
        mem_rd     = 1'b1;
        state_nxt  = RD_PC;
      end
      RD_PC: begin
        mem_sel_sp = 1'b1;
        mem_rd     = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sp        <= STACK_TOP;
      op_q      <= OP_PUSH;
      push_q    <= 8'h00;
      pc_q      <= 8'h00;
      flags_q   <= 8'h00;
      fail_pend <= 1'b0;
      fail_ovf  <= 1'b0;
      done      <= 1'b0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      pop_data  <= 8'h00;
      pc_out    <= 8'h00;
      flags_out <= 8'h00;
    end else begin
      state     <= state_nxt;
      done      <= fail_pend || ((state != IDLE) && (state_nxt == IDLE));
      fail_pend <= accept && !op_ok;
      if (accept) begin
        op_q     <= op_code;
        push_q   <= push_data;
        pc_q     <= pc_in;
        flags_q  <= flags_in;
        fail_ovf <= (op_code == OP_PUSH) || (op_code == OP_CALL);
      end
      case (state)
        WR, WR_PC, WR_FL: sp <= sp - 8'd1;
        INC:              sp <= sp + 8'd1;
        RD:               pop_data <= mem_dout;
        RD_FL: begin
          sp        <= sp + 8'd1;
          flags_out <= mem_dout;
        end
        RD_PC:            pc_out <= mem_dout;
        default: ;
      endcase
      // A fresh error outranks a simultaneous clear.
      if (fail_pend && fail_ovf)       err_ovf <= 1'b1;
      else if (err_clr)                err_ovf <= 1'b0;
      if (fail_pend && !fail_ovf)      err_unf <= 1'b1;
      else if (err_clr)                err_unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboarded bench for stack_ctrl with a behavioural data memory on the SP port.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam logic [7:0] TOP = 8'hFF;
  localparam logic [7:0] BOT = 8'hC0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [1:0] op_code = 2'b00;
  logic       op_ready;
  logic [7:0] push_data = 8'h00, pc_in = 8'h00, flags_in = 8'h00;
  logic       err_clr = 1'b0;
  logic [7:0] mem_dout, sp_out, mem_din, pop_data, pc_out, flags_out;
  logic       mem_sel_sp, mem_rd, mem_wr, done, err_ovf, err_unf;

  stack_ctrl #(.STACK_TOP(TOP), .STACK_BOTTOM(BOT)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .push_data(push_data), .pc_in(pc_in), .flags_in(flags_in), .err_clr(err_clr),
    .mem_dout(mem_dout), .sp_out(sp_out), .mem_sel_sp(mem_sel_sp), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_din(mem_din), .pop_data(pop_data), .pc_out(pc_out),
    .flags_out(flags_out), .done(done), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] last_wr_addr = 8'h00, last_wr_data = 8'h00, last_rd_addr = 8'h00;

  assign mem_dout = mem_sel_sp ? mem[sp_out] : 8'h00;

  always @(posedge clk) begin
    if (mem_wr && mem_sel_sp) begin
      mem[sp_out]  <= mem_din;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= sp_out;
      last_wr_data <= mem_din;
    end
    if (mem_rd && mem_sel_sp) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= sp_out;
    end
  end

  typedef struct {
    int         lat;
    int         nwr;
    int         nrd;
    logic [7:0] sp, pop, pc, fl;
    logic       ovf, unf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_stk [0:255];
  logic [7:0] m_sp, m_pop, m_pc, m_fl;
  logic       m_ovf, m_unf;
  int         checks = 0;
  int         failures = 0;

  task automatic model_reset();
    m_sp = TOP; m_pop = 8'h00; m_pc = 8'h00; m_fl = 8'h00;
    m_ovf = 1'b0; m_unf = 1'b0;
    sb.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; op_valid = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Predicts the outcome into the scoreboard, then issues the op and waits (bounded) for done.
  task automatic do_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] pc,
                       input logic [7:0] fl, output int lat, output int nwr, output int nrd);
    exp_t e;
    int w0, r0, n;
    logic [7:0] occ;
    occ = TOP - m_sp;
    e.lat = 1; e.nwr = 0; e.nrd = 0;
    case (op)
      OP_PUSH: if (m_sp >= BOT) begin
        m_stk[m_sp] = d; m_sp = m_sp - 8'd1; e.nwr = 1;
      end else m_ovf = 1'b1;
      OP_CALL: if (m_sp > BOT) begin
        m_stk[m_sp] = pc; m_stk[8'(m_sp - 8'd1)] = fl; m_sp = m_sp - 8'd2; e.nwr = 2; e.lat = 2;
      end else m_ovf = 1'b1;
      OP_POP: if (occ >= 8'd1) begin
        m_sp = m_sp + 8'd1; m_pop = m_stk[m_sp]; e.nrd = 1; e.lat = 2;
      end else m_unf = 1'b1;
      default: if (occ >= 8'd2) begin
        m_fl = m_stk[8'(m_sp + 8'd1)]; m_pc = m_stk[8'(m_sp + 8'd2)]; m_sp = m_sp + 8'd2;
        e.nrd = 2; e.lat = 3;
      end else m_unf = 1'b1;
    endcase
    e.sp = m_sp; e.pop = m_pop; e.pc = m_pc; e.fl = m_fl; e.ovf = m_ovf; e.unf = m_unf;
    sb.push_back(e);
    w0 = wr_cnt; r0 = rd_cnt;
    op_valid = 1'b1; op_code = op; push_data = d; pc_in = pc; flags_in = fl;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = -1; n = 0;
    while (lat < 0 && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) lat = n;
    end
    nwr = wr_cnt - w0;
    nrd = rd_cnt - r0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (sp_out !== TOP) begin failures++; $display("FAIL reset_sp got=%h exp=%h", sp_out, TOP); end
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
    checks++; if ({done, mem_wr, mem_rd, mem_sel_sp, err_ovf, err_unf} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000", {done, mem_wr, mem_rd, mem_sel_sp, err_ovf, err_unf}); end
    checks++; if ({pop_data, pc_out, flags_out, mem_din} !== 32'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=00000000", {pop_data, pc_out, flags_out, mem_din}); end
  endtask

  task automatic test_push();
    exp_t e; int lat, nwr, nrd;
    do_op(OP_PUSH, 8'hA5, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL push_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (nwr !== e.nwr) begin failures++; $display("FAIL push_nwr got=%0d exp=%0d", nwr, e.nwr); end
    checks++; if ({last_wr_addr, last_wr_data} !== 16'hFFA5) begin
      failures++; $display("FAIL push_write got=%h/%h exp=ff/a5", last_wr_addr, last_wr_data); end
    checks++; if (sp_out !== e.sp) begin failures++; $display("FAIL push_sp got=%h exp=%h", sp_out, e.sp); end
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL push_ready_in_done got=%b exp=1", op_ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL push_done_width got=%b exp=0", done); end
  endtask

  task automatic test_pop();
    exp_t e; int lat, nwr, nrd;
    do_op(OP_POP, 8'h00, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin failures++; $display("FAIL pop_lat got=%0d exp=%0d", lat, e.lat); end
    checks++; if (pop_data !== e.pop) begin failures++; $display("FAIL pop_data got=%h exp=%h", pop_data, e.pop); end
    checks++; if (sp_out !== e.sp) begin failures++; $display("FAIL pop_sp got=%h exp=%h", sp_out, e.sp); end
    checks++; if (nrd !== e.nrd || last_rd_addr !== 8'hFF) begin
      failures++; $display("FAIL pop_read got=%0d@%h exp=%0d@ff", nrd, last_rd_addr, e.nrd); end
  endtask

  task automatic test_call_ret();
    exp_t e; int lat, nwr, nrd;
    do_op(OP_CALL, 8'h00, 8'h3C, 8'h05, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (lat !== e.lat || nwr !== e.nwr) begin
      failures++; $display("FAIL call_timing got=%0d/%0d exp=%0d/%0d", lat, nwr, e.lat, e.nwr); end
    checks++; if ({mem[8'hFF], mem[8'hFE]} !== 16'h3C05) begin
      failures++; $display("FAIL call_mem got=%h%h exp=3c05", mem[8'hFF], mem[8'hFE]); end
    checks++; if (sp_out !== e.sp) begin failures++; $display("FAIL call_sp got=%h exp=%h", sp_out, e.sp); end
    do_op(OP_RET, 8'h00, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (lat !== e.lat || nrd !== e.nrd) begin
      failures++; $display("FAIL ret_timing got=%0d/%0d exp=%0d/%0d", lat, nrd, e.lat, e.nrd); end
    checks++; if ({pc_out, flags_out} !== {e.pc, e.fl}) begin
      failures++; $display("FAIL ret_data got=%h/%h exp=%h/%h", pc_out, flags_out, e.pc, e.fl); end
    checks++; if (sp_out !== e.sp) begin failures++; $display("FAIL ret_sp got=%h exp=%h", sp_out, e.sp); end
  endtask

  task automatic test_underflow();
    exp_t e; int lat, nwr, nrd;
    do_op(OP_POP, 8'h00, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (lat !== e.lat || nrd !== 0) begin
      failures++; $display("FAIL unf_pop_timing got=%0d/%0d exp=%0d/0", lat, nrd, e.lat); end
    checks++; if (err_unf !== e.unf || sp_out !== e.sp) begin
      failures++; $display("FAIL unf_pop_flag got=%b/%h exp=%b/%h", err_unf, sp_out, e.unf, e.sp); end
    clear_err();
    checks++; if (err_unf !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", err_unf); end
    err_clr = 1'b1;
    do_op(OP_POP, 8'h00, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    err_clr = 1'b0;
    checks++; if (err_unf !== e.unf) begin failures++; $display("FAIL unf_error_wins got=%b exp=%b", err_unf, e.unf); end
    clear_err();
    do_op(OP_PUSH, 8'h66, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    do_op(OP_RET, 8'h00, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (err_unf !== e.unf || nrd !== 0 || sp_out !== e.sp) begin
      failures++; $display("FAIL unf_ret got=%b/%0d/%h exp=%b/0/%h", err_unf, nrd, sp_out, e.unf, e.sp); end
    do_op(OP_POP, 8'h00, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (pop_data !== e.pop) begin failures++; $display("FAIL unf_drain got=%h exp=%h", pop_data, e.pop); end
    clear_err();
  endtask

  task automatic test_overflow();
    exp_t e; int lat, nwr, nrd;
    apply_reset();
    for (int i = 0; i < 64; i++) begin
      do_op(OP_PUSH, 8'(i) ^ 8'h5A, 8'h00, 8'h00, lat, nwr, nrd);
      e = sb.pop_front();
      checks++; if (lat !== e.lat || nwr !== e.nwr) begin
        failures++; $display("FAIL fill_push%0d got=%0d/%0d exp=%0d/%0d", i, lat, nwr, e.lat, e.nwr); end
    end
    checks++; if (sp_out !== 8'hBF || err_ovf !== 1'b0) begin
      failures++; $display("FAIL fill_full got=%h/%b exp=bf/0", sp_out, err_ovf); end
    do_op(OP_PUSH, 8'hEE, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (err_ovf !== e.ovf || nwr !== 0 || lat !== e.lat || sp_out !== e.sp) begin
      failures++; $display("FAIL ovf_push got=%b/%0d/%0d/%h exp=%b/0/%0d/%h", err_ovf, nwr, lat, sp_out, e.ovf, e.lat, e.sp); end
    clear_err();
    do_op(OP_POP, 8'h00, 8'h00, 8'h00, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (pop_data !== e.pop || sp_out !== e.sp) begin
      failures++; $display("FAIL ovf_pop got=%h/%h exp=%h/%h", pop_data, sp_out, e.pop, e.sp); end
    do_op(OP_CALL, 8'h00, 8'h12, 8'h34, lat, nwr, nrd);
    e = sb.pop_front();
    checks++; if (err_ovf !== e.ovf || nwr !== 0 || sp_out !== e.sp || lat !== e.lat) begin
      failures++; $display("FAIL ovf_call got=%b/%0d/%h/%0d exp=%b/0/%h/%0d", err_ovf, nwr, sp_out, lat, e.ovf, e.sp, e.lat); end
  endtask

  task automatic test_reset_mid();
    int w0;
    logic wr_seen;
    apply_reset();
    w0 = wr_cnt;
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_CALL; pc_in = 8'h77; flags_in = 8'h88;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    wr_seen = mem_wr;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_seen !== 1'b1 || mem_wr !== 1'b0) begin
      failures++; $display("FAIL rstmid_strobe got=%b->%b exp=1->0", wr_seen, mem_wr); end
    checks++; if (sp_out !== TOP || op_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_state got=%h/%b exp=ff/1", sp_out, op_ready); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (wr_cnt - w0 !== 1 || mem[8'hFF] !== 8'h77) begin
      failures++; $display("FAIL rstmid_writes got=%0d/%h exp=1/77", wr_cnt - w0, mem[8'hFF]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_push();
    test_pop();
    test_call_ret();
    test_underflow();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
